axis_psum_reducer: RTL and testbench



---
 rtl/mvm_noc_pkg.sv | 25 ++
 rtl/axis_psum_reducer_if.sv | 31 +++
 rtl/axis_sync_fifo.sv | 50 +++++
 rtl/axis_psum_reducer.sv | 148 ++++++++++++++
 tb/tb_axis_psum_reducer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_noc_pkg.sv
// Shared types and elaboration-time helpers for the MVM NoC stream blocks.
package mvm_noc_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int lanes(input int dataw, input int oprec);
    return dataw / oprec;
  endfunction

  function automatic int sat_max(input int oprec);
    return (1 << (oprec - 1)) - 1;
  endfunction

  function automatic int sat_min(input int oprec);
    return -(1 << (oprec - 1));
  endfunction

endpackage

// File: rtl/axis_psum_reducer_if.sv
// Per-channel AXI-Stream inputs and the single reduced output stream.
interface axis_psum_reducer_if #(
  parameter int CHANNELS = 2,
  parameter int DATAW    = 32,
  parameter int DESTW    = 6,
  parameter int USERW    = 32
);
  logic [CHANNELS-1:0]       s_tvalid;
  logic [CHANNELS-1:0]       s_tready;
  logic [CHANNELS*DATAW-1:0] s_tdata;
  logic [CHANNELS-1:0]       s_tlast;
  logic [CHANNELS*DESTW-1:0] s_tdest;
  logic [CHANNELS*USERW-1:0] s_tuser;
  logic                      m_tvalid;
  logic                      m_tready;
  logic [DATAW-1:0]          m_tdata;
  logic                      m_tlast;
  logic [DESTW-1:0]          m_tdest;
  logic [USERW-1:0]          m_tuser;

  // The reducer sinks the s_* streams and sources the m_* stream.
  modport slave (
    input  s_tvalid, s_tdata, s_tlast, s_tdest, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, s_tdest, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser
  );
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered count; a pop on a full FIFO frees the slot for a same-cycle push.
module axis_sync_fifo
  import mvm_noc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             wr, rd;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr      = push_i & (~full_o | pop_i);
  // Reads come only from stored entries, so push+pop on empty never bypasses.
  assign rd      = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/axis_psum_reducer.sv
// N-channel AXI-Stream partial-sum reducer: aligns one beat from every active channel
// and emits their lane-wise signed sum through a single output register.
module axis_psum_reducer
  import mvm_noc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATAW      = 32,
  parameter int OPRECISION = 8,
  parameter int DESTW      = 6,
  parameter int USERW      = 32,
  parameter int FIFOD      = 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] cfg_chan_mask,
  axis_psum_reducer_if.slave  bus,
  output logic                err_tlast_mismatch,
  output logic [15:0]         pkt_count
);
  localparam int LANES = lanes(DATAW, OPRECISION);
  localparam int SW    = OPRECISION + clog2(CHANNELS);
  localparam int FW    = DATAW + USERW + DESTW + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(sat_max(OPRECISION));
  localparam logic signed [SW-1:0] SMIN = SW'(sat_min(OPRECISION));

  state_e                       state_q, state_d;
  logic [CHANNELS-1:0]          active_q, active_d;
  logic [CHANNELS-1:0]          full, empty, push, pop, s_rdy;
  logic [CHANNELS-1:0][FW-1:0]  head;
  logic                         fire;

  logic                         m_tvalid_q, m_tlast_q, err_q;
  logic [DATAW-1:0]             m_tdata_q, data_d;
  logic [DESTW-1:0]             m_tdest_q, dest_sel;
  logic [USERW-1:0]             m_tuser_q, user_sum;
  logic [15:0]                  pkt_q;
  logic                         last_sel, mismatch;
  logic signed [SW-1:0]         acc;
  logic [OPRECISION-1:0]        ln, res;

  // Inactive channels are always ready and their beats fall on the floor.
  assign s_rdy = ~{CHANNELS{rst}} & (~active_q | ~full);
  assign push  = bus.s_tvalid & s_rdy & active_q;
  assign fire  = (|active_q) & ~(|(empty & active_q)) & (~m_tvalid_q | bus.m_tready);
  assign pop   = {CHANNELS{fire}} & active_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    axis_sync_fifo #(.WIDTH(FW), .DEPTH(FIFOD)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[c]),
      .din_i   ({bus.s_tlast[c], bus.s_tdest[c*DESTW +: DESTW],
                 bus.s_tuser[c*USERW +: USERW], bus.s_tdata[c*DATAW +: DATAW]}),
      .pop_i   (pop[c]),
      .dout_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  always_comb begin
    dest_sel = '0;
    last_sel = 1'b0;
    user_sum = '0;
    mismatch = 1'b0;
    data_d   = '0;
    acc      = '0;
    ln       = '0;
    res      = '0;
    // Descending scan so the lowest active channel wins dest/last.
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (active_q[c]) begin
        dest_sel = head[c][DATAW+USERW +: DESTW];
        last_sel = head[c][FW-1];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (active_q[c]) begin
        user_sum = user_sum + head[c][DATAW +: USERW];
        if (head[c][FW-1] != last_sel) mismatch = 1'b1;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      acc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (active_q[c]) begin
          ln  = head[c][l*OPRECISION +: OPRECISION];
          acc = acc + {{(SW-OPRECISION){ln[OPRECISION-1]}}, ln};
        end
      end
      if (SATURATE && (acc > SMAX))      res = SMAX[OPRECISION-1:0];
      else if (SATURATE && (acc < SMIN)) res = SMIN[OPRECISION-1:0];
      else                               res = acc[OPRECISION-1:0];
      data_d[l*OPRECISION +: OPRECISION] = res;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        active_d = cfg_chan_mask;
        if (fire && !last_sel) state_d = BUSY;
      end
      BUSY: if (fire && last_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      active_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tdest_q  <= '0;
      m_tuser_q  <= '0;
      err_q      <= 1'b0;
      pkt_q      <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      if (fire) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= data_d;
        m_tlast_q  <= last_sel;
        m_tdest_q  <= dest_sel;
        m_tuser_q  <= user_sum;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (fire && mismatch) err_q <= 1'b1;
      if (m_tvalid_q && bus.m_tready && m_tlast_q) pkt_q <= pkt_q + 16'd1;
    end
  end

  assign bus.s_tready       = s_rdy;
  assign bus.m_tvalid       = m_tvalid_q;
  assign bus.m_tdata        = m_tdata_q;
  assign bus.m_tlast        = m_tlast_q;
  assign bus.m_tdest        = m_tdest_q;
  assign bus.m_tuser        = m_tuser_q;
  assign err_tlast_mismatch = err_q;
  assign pkt_count          = pkt_q;
endmodule

// File: tb/tb_axis_psum_reducer.sv
// Directed bench for axis_psum_reducer: a saturating and a wrapping instance share stimulus.
module tb_axis_psum_reducer;
  logic        clk, rst;
  logic [1:0]  cfg;
  logic        err, err2;
  logic [15:0] pkt, pkt2;
  int          checks, errors;
  int          k, j;
  logic        acc_ok;
  logic [31:0] a [3];
  logic [31:0] b [3];

  axis_psum_reducer_if #(.CHANNELS(2), .DATAW(32), .DESTW(6), .USERW(32)) bus ();
  axis_psum_reducer_if #(.CHANNELS(2), .DATAW(32), .DESTW(6), .USERW(32)) bus2 ();

  assign bus2.s_tvalid = bus.s_tvalid;
  assign bus2.s_tdata  = bus.s_tdata;
  assign bus2.s_tlast  = bus.s_tlast;
  assign bus2.s_tdest  = bus.s_tdest;
  assign bus2.s_tuser  = bus.s_tuser;
  assign bus2.m_tready = bus.m_tready;

  axis_psum_reducer #(.CHANNELS(2), .DATAW(32), .OPRECISION(8), .DESTW(6), .USERW(32),
                      .FIFOD(4), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_chan_mask(cfg), .bus(bus),
    .err_tlast_mismatch(err), .pkt_count(pkt));

  axis_psum_reducer #(.CHANNELS(2), .DATAW(32), .OPRECISION(8), .DESTW(6), .USERW(32),
                      .FIFOD(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .cfg_chan_mask(cfg), .bus(bus2),
    .err_tlast_mismatch(err2), .pkt_count(pkt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int c, input logic v, input logic [31:0] d, input logic l,
                     input logic [31:0] u, input logic [5:0] dst);
    bus.s_tvalid[c]         = v;
    bus.s_tdata[c*32 +: 32] = d;
    bus.s_tlast[c]          = l;
    bus.s_tuser[c*32 +: 32] = u;
    bus.s_tdest[c*6 +: 6]   = dst;
  endtask

  function automatic logic [31:0] bp0(input int n);
    return 32'h01010101 * (n + 1);
  endfunction

  function automatic logic [31:0] bp1(input int n);
    return 32'h00000100 * (n + 1);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cfg = 2'b11;
    bus.m_tready = 1'b1;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.s_tuser  = '0;
    bus.s_tdest  = '0;
    tick(); tick(); tick();
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_s_tready", bus.s_tready, 2'b00);
    chk("rst_m_tdata", bus.m_tdata, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("idle_s_tready", bus.s_tready, 2'b11);

    // Basic two-channel add
    drv(0, 1, 32'h01020304, 1, 5, 6'd3);
    drv(1, 1, 32'h10203040, 1, 7, 6'd9);
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    chk("basic_lat1", bus.m_tvalid, 0);
    tick();
    chk("basic_valid", bus.m_tvalid, 1);
    chk("basic_data", bus.m_tdata, 32'h11223344);
    chk("basic_user", bus.m_tuser, 12);
    chk("basic_last", bus.m_tlast, 1);
    chk("basic_dest", bus.m_tdest, 3);
    tick();
    chk("basic_pkt", pkt, 1);
    chk("basic_drained", bus.m_tvalid, 0);

    // Saturate vs wrap on the two instances
    drv(0, 1, 32'h0005807F, 1, 0, 0);
    drv(1, 1, 32'h00FBFF01, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("sat_data", bus.m_tdata, 32'h0000807F);
    chk("wrap_data", bus2.m_tdata, 32'h00007F80);
    tick();
    chk("sat_pkt", pkt, 2);

    // Skewed channels
    a[0] = 32'h01000001; a[1] = 32'h02000002; a[2] = 32'h03000003;
    b[0] = 32'h00100010; b[1] = 32'h00200020; b[2] = 32'h00300030;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, a[i], i == 2, 0, 0);
      tick();
      chk("skew_quiet_a", bus.m_tvalid, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    tick(); chk("skew_quiet_b", bus.m_tvalid, 0);
    tick(); chk("skew_quiet_c", bus.m_tvalid, 0);
    drv(1, 1, b[0], 0, 0, 0);
    tick(); chk("skew_quiet_d", bus.m_tvalid, 0);
    drv(1, 1, b[1], 0, 0, 0);
    tick();
    chk("skew_v0", bus.m_tvalid, 1);
    chk("skew_d0", bus.m_tdata, 32'h01100011);
    chk("skew_l0", bus.m_tlast, 0);
    drv(1, 1, b[2], 1, 0, 0);
    tick();
    chk("skew_d1", bus.m_tdata, 32'h02200022);
    chk("skew_l1", bus.m_tlast, 0);
    drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("skew_d2", bus.m_tdata, 32'h03300033);
    chk("skew_l2", bus.m_tlast, 1);
    tick();
    chk("skew_done", bus.m_tvalid, 0);
    chk("skew_pkt", pkt, 3);

    // Back-pressure: 4 in the FIFO plus 1 in the output register
    bus.m_tready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drv(0, 1, bp0(k), k == 7, 0, 0);
      drv(1, 1, bp1(k), k == 7, 0, 0);
      if (&bus.s_tready) begin
        tick();
        k++;
      end else break;
    end
    chk("bp_accepted", k, 5);
    for (int cyc = 0; cyc < 3; cyc++) begin
      chk("bp_hold_valid", bus.m_tvalid, 1);
      chk("bp_hold_data", bus.m_tdata, bp0(0) + bp1(0));
      chk("bp_hold_ready", bus.s_tready, 2'b00);
      tick();
    end
    bus.m_tready = 1'b1;
    j = 0;
    for (int cyc = 0; cyc < 40 && j < 8; cyc++) begin
      if (k < 8) begin
        drv(0, 1, bp0(k), k == 7, 0, 0);
        drv(1, 1, bp1(k), k == 7, 0, 0);
      end else begin
        drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
      end
      acc_ok = (k < 8) && (&bus.s_tready);
      if (bus.m_tvalid) begin
        chk("bp_data", bus.m_tdata, bp0(j) + bp1(j));
        chk("bp_last", bus.m_tlast, j == 7);
        j++;
      end
      tick();
      if (acc_ok) k++;
    end
    chk("bp_all_out", j, 8);
    chk("bp_pkt", pkt, 4);
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("bp_idle", bus.m_tvalid, 0);

    // Channel mask: ch0 dropped
    cfg = 2'b10;
    tick();
    chk("mask_ready", bus.s_tready, 2'b11);
    drv(0, 1, 32'hDEADBEEF, 1, 3, 6'd1);
    drv(1, 1, 32'h12345678, 1, 4, 6'd2);
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("mask_data", bus.m_tdata, 32'h12345678);
    chk("mask_user", bus.m_tuser, 4);
    chk("mask_dest", bus.m_tdest, 2);
    tick();
    chk("mask_pkt", pkt, 5);

    // tlast disagreement
    cfg = 2'b11;
    tick();
    drv(0, 1, 32'h00000001, 1, 0, 0);
    drv(1, 1, 32'h00000002, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    chk("mm_err_before", err, 0);
    tick();
    chk("mm_valid", bus.m_tvalid, 1);
    chk("mm_data", bus.m_tdata, 32'h00000003);
    chk("mm_last", bus.m_tlast, 1);
    chk("mm_err", err, 1);
    tick(); tick();
    chk("mm_err_sticky", err, 1);
    chk("mm_pkt", pkt, 6);

    // Reset in the middle of a 4-beat packet
    drv(0, 1, 32'h05050505, 0, 0, 0);
    drv(1, 1, 32'h05050505, 0, 0, 0);
    tick();
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("mrst_valid", bus.m_tvalid, 0);
    chk("mrst_pkt", pkt, 0);
    chk("mrst_err", err, 0);
    chk("mrst_ready", bus.s_tready, 2'b00);
    rst = 1'b0;
    tick();
    chk("mrst_empty0", bus.m_tvalid, 0);
    tick();
    chk("mrst_empty1", bus.m_tvalid, 0);
    drv(0, 1, 32'h01020304, 1, 0, 0);
    drv(1, 1, 32'h01010101, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("fresh_valid", bus.m_tvalid, 1);
    chk("fresh_data", bus.m_tdata, 32'h02030405);
    chk("fresh_last", bus.m_tlast, 1);
    tick();
    chk("fresh_pkt", pkt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
